// File: rtl/frame_reader.sv
// Raster reader: sweeps the 160x120 board RAM on each frame_go and streams cells to the VGA adapter.
// Optional build macro FRAME_READER_SKIP_BLACK_EN suppresses plot strobes for black (3'b000) cells.
module frame_reader #(
   parameter logic [7:0] X_MAX = 8'd159,
   parameter logic [6:0] Y_MAX = 7'd119
) (
   input  logic        CLOCK_50,
   input  logic        resetn,
   input  logic        frame_go,
   input  logic        hold,
   output logic [14:0] rd_address,
   output logic        rd_en,
   input  logic [2:0]  rd_q,
   output logic [7:0]  x,
   output logic [6:0]  y,
   output logic [2:0]  colour,
   output logic        plot,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] cx_q, cx_d;
   logic [6:0] cy_q, cy_d;
   logic       last_cell;

   // Stage 1: coordinates of the read whose data arrives this cycle.
   logic       s1_valid_q;
   logic       s1_last_q;
   logic [7:0] s1_x_q;
   logic [6:0] s1_y_q;

   // Stage 2: registered pixel presented to the VGA adapter.
   logic [7:0] x_q;
   logic [6:0] y_q;
   logic [2:0] colour_q;
   logic       plot_q;
   logic       plot_d;
   logic       done_q;

   assign last_cell = (cx_q == X_MAX) && (cy_q == Y_MAX);

   always_comb begin
      // NOTE: every output of this block is given a default first, so no path can infer a latch.
      state_d = state_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      rd_en   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (frame_go) begin
               state_d = SCAN;
               cx_d    = 8'd0;
               cy_d    = 7'd0;
            end
         end
         SCAN: begin
            if (!hold) begin
               rd_en = 1'b1;
               if (last_cell) begin
                  // Park counters at the origin so the idle address reads as zero.
                  state_d = DRAIN;
                  cx_d    = 8'd0;
                  cy_d    = 7'd0;
               end else if (cx_q == X_MAX) begin
                  cx_d = 8'd0;
                  cy_d = cy_q + 7'd1;
               end else begin
                  cx_d = cx_q + 8'd1;
               end
            end
         end
         DRAIN: begin
            if (done_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef FRAME_READER_SKIP_BLACK_EN
   assign plot_d = s1_valid_q && (rd_q != 3'b000);
`else
   assign plot_d = s1_valid_q;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cx_q    <= 8'd0;
         cy_q    <= 7'd0;
      end else begin
         state_q <= state_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_x_q     <= 8'd0;
         s1_y_q     <= 7'd0;
         x_q        <= 8'd0;
         y_q        <= 7'd0;
         colour_q   <= 3'd0;
         plot_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         s1_valid_q <= rd_en;
         s1_last_q  <= rd_en && last_cell;
         if (rd_en) begin
            s1_x_q <= cx_q;
            s1_y_q <= cy_q;
         end
         // Pixel registers hold their last value between plots.
         if (s1_valid_q) begin
            x_q      <= s1_x_q;
            y_q      <= s1_y_q;
            colour_q <= rd_q;
         end
         plot_q <= plot_d;
         done_q <= s1_last_q;
      end
   end

   assign rd_address = {cx_q, cy_q};
   assign busy       = (state_q != IDLE);
   assign x          = x_q;
   assign y          = y_q;
   assign colour     = colour_q;
   assign plot       = plot_q;
   assign done       = done_q;

endmodule

// File: tb/tb_frame_reader.sv
// Directed bench for frame_reader: RAM model plus a scoreboard of expected pixels and plot cycles.
module tb_frame_reader;

`ifdef FRAME_READER_SKIP_BLACK_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif
   localparam int CELLS    = 19200;
   localparam int HOLD_IDX = 80 + 10 * 160;
   localparam int HOLD_LEN = 5;

   typedef struct {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
      int         cyc;
   } pix_t;

   logic        CLOCK_50;
   logic        resetn;
   logic        frame_go;
   logic        hold;
   logic [14:0] rd_address;
   logic        rd_en;
   logic [2:0]  rd_q;
   logic [7:0]  x;
   logic [6:0]  y;
   logic [2:0]  colour;
   logic        plot;
   logic        busy;
   logic        done;

   int   n_assert = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   plot_cnt = 0;
   int   done_cnt = 0;
   int   done_cyc = -1;
   pix_t q[$];

   frame_reader dut (
      .CLOCK_50  (CLOCK_50),
      .resetn    (resetn),
      .frame_go  (frame_go),
      .hold      (hold),
      .rd_address(rd_address),
      .rd_en     (rd_en),
      .rd_q      (rd_q),
      .x         (x),
      .y         (y),
      .colour    (colour),
      .plot      (plot),
      .busy      (busy),
      .done      (done)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) cyc <= cyc + 1;

   function automatic logic [2:0] ram_col(input logic [7:0] cx, input logic [6:0] cy);
      if (SKIP) return (cx == 8'd3 && cy == 7'd4) ? 3'd1 : 3'd0;
      return cx[2:0];
   endfunction

   initial rd_q = 3'd0;
   always @(posedge CLOCK_50) rd_q <= ram_col(rd_address[14:7], rd_address[6:0]);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge CLOCK_50);
      #1;
   endtask

   // Expected pixels of one frame in raster order, with the cycle each must appear in.
   task automatic push_frame(input int f0, input bit with_hold, output int n);
      pix_t p;
      n = 0;
      for (int i = 0; i < CELLS; i++) begin
         p.x   = 8'(i % 160);
         p.y   = 7'(i / 160);
         p.c   = ram_col(p.x, p.y);
         p.cyc = f0 + 3 + i + ((with_hold && i >= HOLD_IDX) ? HOLD_LEN : 0);
         if (!SKIP || p.c != 3'd0) begin
            q.push_back(p);
            n++;
         end
      end
   endtask

   function automatic int count_plots(input int n);
      int c = 0;
      for (int i = 0; i < n; i++)
         if (!SKIP || ram_col(8'(i % 160), 7'(i / 160)) != 3'd0) c++;
      return c;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_rd_address"}, 32'(rd_address), 0);
      check({tag, "_rd_en"},      32'(rd_en),      0);
      check({tag, "_x"},          32'(x),          0);
      check({tag, "_y"},          32'(y),          0);
      check({tag, "_colour"},     32'(colour),     0);
      check({tag, "_plot"},       32'(plot),       0);
      check({tag, "_busy"},       32'(busy),       0);
      check({tag, "_done"},       32'(done),       0);
   endtask

   task automatic wait_done(input string tag, input int budget);
      int k = 0;
      while (done_cnt == 0 && k < budget) begin
         step();
         k++;
      end
      check({tag, "_done_seen"}, 32'(done_cnt), 1);
   endtask

   always @(negedge CLOCK_50) begin
      pix_t e;
      if (plot) begin
         plot_cnt++;
         if (q.size() == 0) begin
            check("unexpected_plot", 32'(plot), 0);
         end else begin
            e = q.pop_front();
            check("plot_x",      32'(x),      32'(e.x));
            check("plot_y",      32'(y),      32'(e.y));
            check("plot_colour", 32'(colour), 32'(e.c));
            check("plot_cycle",  32'(cyc),    32'(e.cyc));
         end
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int  f0, n_exp, k_hold, pc0, k;
      bit  found;

      resetn   = 1'b0;
      frame_go = 1'b0;
      hold     = 1'b0;
      repeat (3) step();
      check_all_zero("reset");
      resetn = 1'b1;
      repeat (2) step();

      // Frame 1: unstalled, with ignored frame_go pulses mid-frame and on the done cycle.
      f0 = cyc;
      push_frame(f0, 1'b0, n_exp);
      plot_cnt = 0;
      done_cnt = 0;
      frame_go = 1'b1;
      step();
      frame_go = 1'b0;
      check("c1_busy",       32'(busy),       1);
      check("c1_rd_en",      32'(rd_en),      1);
      check("c1_rd_address", 32'(rd_address), 0);
      for (int kk = 2; kk <= 19202; kk++) begin
         step();
         frame_go = (kk == 500 || kk == 19202);
         if (kk == 19202) begin
            check("f1_busy_done_cycle", 32'(busy), 1);
            check("f1_done_level",      32'(done), 1);
         end
      end
      step();
      check("f1_busy_after_done", 32'(busy),     0);
      check("f1_done_cycle",      32'(done_cyc), 32'(f0 + 19202));
      check("f1_done_count",      32'(done_cnt), 1);
      check("f1_plot_count",      32'(plot_cnt), 32'(n_exp));
      check("f1_queue_empty",     32'(q.size()), 0);

      // Frame 2: started on cycle 19203 of frame 1, stalled for 5 cycles at cell (80,10).
      f0 = cyc;
      push_frame(f0, 1'b1, n_exp);
      plot_cnt = 0;
      done_cnt = 0;
      frame_go = 1'b1;
      step();
      frame_go = 1'b0;
      found = 1'b0;
      k = 0;
      while (!found && k < 5000) begin
         if (rd_address == {8'd80, 7'd10}) found = 1'b1;
         else begin
            step();
            k++;
         end
      end
      check("hold_addr_reached", 32'(found), 1);
      hold   = 1'b1;
      k_hold = cyc;
      pc0    = plot_cnt;
      #1;
      check("hold_rd_en",      32'(rd_en),      0);
      check("hold_rd_address", 32'(rd_address), 32'({8'd80, 7'd10}));
      for (int kk = 1; kk < HOLD_LEN; kk++) begin
         step();
         check("hold_rd_en",      32'(rd_en),      0);
         check("hold_rd_address", 32'(rd_address), 32'({8'd80, 7'd10}));
      end
      check("hold_cycle_index", 32'(cyc - k_hold), 32'(HOLD_LEN - 1));
      // Plots produced after the stall took effect: only the in-flight (79,10) read.
      check("hold_plots_in_window", 32'(plot_cnt - pc0),
            (!SKIP || ram_col(8'd79, 7'd10) != 3'd0) ? 32'd1 : 32'd0);
      step();
      hold = 1'b0;
      wait_done("f2", 20000);
      check("f2_done_cycle",  32'(done_cyc), 32'(f0 + 19202 + HOLD_LEN));
      check("f2_plot_count",  32'(plot_cnt), 32'(n_exp));
      check("f2_queue_empty", 32'(q.size()), 0);
      step();
      check("f2_busy_after_done", 32'(busy), 0);

      // Frame 3: asynchronous reset after the 5000th pixel's plot cycle.
      f0 = cyc;
      push_frame(f0, 1'b0, n_exp);
      plot_cnt = 0;
      done_cnt = 0;
      frame_go = 1'b1;
      step();
      frame_go = 1'b0;
      while (cyc < f0 + 5002) step();
      check("f3_plots_before_reset", 32'(plot_cnt), 32'(count_plots(5000)));
      #2;
      resetn = 1'b0;
      #1;
      check_all_zero("async_reset");
      q.delete();
      pc0 = plot_cnt;
      repeat (3) step();
      check("reset_no_plots", 32'(plot_cnt - pc0), 0);
      check("reset_plot",     32'(plot),           0);
      resetn = 1'b1;
      step();

      // Frame 4: restart after reset begins again at (0,0).
      f0 = cyc;
      push_frame(f0, 1'b0, n_exp);
      plot_cnt = 0;
      done_cnt = 0;
      frame_go = 1'b1;
      step();
      frame_go = 1'b0;
      check("f4_c1_rd_address", 32'(rd_address), 0);
      wait_done("f4", 20000);
      check("f4_done_cycle",  32'(done_cyc), 32'(f0 + 19202));
      check("f4_plot_count",  32'(plot_cnt), 32'(n_exp));
      check("f4_queue_empty", 32'(q.size()), 0);
      step();
      check("f4_busy_after_done", 32'(busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
